// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter: widths, source encodings
// and the round-robin source selection.
package cdb_arbiter_pkg;

  localparam int ROB_WIDTH_DEF = 4;
  localparam int DATA_WIDTH    = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } cdb_src_e;

  // On contention the source that did not win last time gets the bus.
  function automatic cdb_src_e pick_source(input logic     alu_ne,
                                           input logic     lsb_ne,
                                           input cdb_src_e last);
    if (alu_ne && lsb_ne) begin
      return (last == SRC_LSB) ? SRC_ALU : SRC_LSB;
    end else if (lsb_ne) begin
      return SRC_LSB;
    end
    return SRC_ALU;
  endfunction

endpackage

// File: rtl/cdb_arbiter_result_fifo.sv
// Small circular result queue: registered count, head always visible, flush
// empties it in one edge. DEPTH must be a power of two so pointers wrap naturally.
module result_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_dat_i,
  input  logic                         pop_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [WIDTH-1:0]             head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Two-requester common-data-bus arbiter: per-source result queues, round-robin
// on contention, one registered broadcast per cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_WIDTH  = ROB_WIDTH_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clockIn,
  input  logic                  resetIn,
  input  logic                  clear,
  input  logic                  aluValid,
  output logic                  aluReady,
  input  logic [ROB_WIDTH-1:0]  aluRobIndex,
  input  logic [31:0]           aluValue,
  input  logic                  lsbValid,
  output logic                  lsbReady,
  input  logic [ROB_WIDTH-1:0]  lsbRobIndex,
  input  logic [31:0]           lsbValue,
  output logic                  cdbValid,
  output logic [ROB_WIDTH-1:0]  cdbRobIndex,
  output logic [31:0]           cdbValue,
  output logic                  cdbSource
);

  localparam int ENTRY_W = ROB_WIDTH + DATA_WIDTH;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

  logic [CNT_W-1:0]   alu_cnt, lsb_cnt;
  logic [ENTRY_W-1:0] alu_head, lsb_head;
  logic               alu_push, lsb_push, alu_pop, lsb_pop;
  logic               alu_ne, lsb_ne, pop_any;
  cdb_src_e           grant_src;

  logic                 valid_q, valid_d;
  logic [ROB_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]          val_q, val_d;
  cdb_src_e             src_q, src_d;
  cdb_src_e             last_grant_q, last_grant_d;

  // Ready looks only at the registered count, so a full queue stays closed even
  // on the cycle it is being drained.
  assign aluReady = !resetIn && !clear && (alu_cnt < CNT_W'(FIFO_DEPTH));
  assign lsbReady = !resetIn && !clear && (lsb_cnt < CNT_W'(FIFO_DEPTH));
  assign alu_push = aluValid && aluReady;
  assign lsb_push = lsbValid && lsbReady;

  assign alu_ne    = (alu_cnt != '0);
  assign lsb_ne    = (lsb_cnt != '0);
  assign grant_src = pick_source(alu_ne, lsb_ne, last_grant_q);
  assign pop_any   = (alu_ne || lsb_ne) && !clear;
  assign alu_pop   = pop_any && (grant_src == SRC_ALU);
  assign lsb_pop   = pop_any && (grant_src == SRC_LSB);

  result_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk_i      (clockIn),
    .rst_i      (resetIn),
    .clear_i    (clear),
    .push_i     (alu_push),
    .push_dat_i ({aluRobIndex, aluValue}),
    .pop_i      (alu_pop),
    .count_o    (alu_cnt),
    .head_o     (alu_head)
  );

  result_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
    .clk_i      (clockIn),
    .rst_i      (resetIn),
    .clear_i    (clear),
    .push_i     (lsb_push),
    .push_dat_i ({lsbRobIndex, lsbValue}),
    .pop_i      (lsb_pop),
    .count_o    (lsb_cnt),
    .head_o     (lsb_head)
  );

  always_comb begin
    valid_d      = pop_any;
    idx_d        = idx_q;
    val_d        = val_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    if (pop_any) begin
      {idx_d, val_d} = (grant_src == SRC_LSB) ? lsb_head : alu_head;
      src_d          = grant_src;
      if (alu_ne && lsb_ne) last_grant_d = grant_src;
    end
  end

  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      valid_q      <= 1'b0;
      idx_q        <= '0;
      val_q        <= '0;
      src_q        <= SRC_ALU;
      last_grant_q <= SRC_LSB;
    end else begin
      valid_q      <= valid_d;
      idx_q        <= idx_d;
      val_q        <= val_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign cdbValid    = valid_q;
  assign cdbRobIndex = idx_q;
  assign cdbValue    = val_q;
  assign cdbSource   = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: latency, round-robin, backpressure, clear, async reset.
module tb_cdb_arbiter;

  logic        clockIn, resetIn, clear;
  logic        aluValid, aluReady, lsbValid, lsbReady;
  logic [3:0]  aluRobIndex, lsbRobIndex, cdbRobIndex;
  logic [31:0] aluValue, lsbValue, cdbValue;
  logic        cdbValid, cdbSource;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]  a_idx [16];
  logic [31:0] a_val [16];
  logic [3:0]  l_idx [16];
  logic [31:0] l_val [16];
  logic [3:0]  e_idx [16];
  logic [31:0] e_val [16];
  logic        e_src [16];
  logic        rdy_log [32];

  cdb_arbiter #(.ROB_WIDTH(4), .FIFO_DEPTH(2)) dut (
    .clockIn     (clockIn),
    .resetIn     (resetIn),
    .clear       (clear),
    .aluValid    (aluValid),
    .aluReady    (aluReady),
    .aluRobIndex (aluRobIndex),
    .aluValue    (aluValue),
    .lsbValid    (lsbValid),
    .lsbReady    (lsbReady),
    .lsbRobIndex (lsbRobIndex),
    .lsbValue    (lsbValue),
    .cdbValid    (cdbValid),
    .cdbRobIndex (cdbRobIndex),
    .cdbValue    (cdbValue),
    .cdbSource   (cdbSource)
  );

  initial begin
    clockIn = 1'b0;
    forever #5 clockIn = ~clockIn;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clockIn);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bcast(input string tag, input logic [3:0] idx, input logic [31:0] val,
                           input logic src);
    chk({tag, "_vld"}, {31'd0, cdbValid}, 32'd1);
    chk({tag, "_idx"}, {28'd0, cdbRobIndex}, {28'd0, idx});
    chk({tag, "_val"}, cdbValue, val);
    chk({tag, "_src"}, {31'd0, cdbSource}, {31'd0, src});
  endtask

  // Each source presents its list in order, advancing only on a completed handshake.
  task automatic run_streams(input int na, input int nl, input int nexp, input int ncyc,
                             input string tag);
    int   ai = 0;
    int   li = 0;
    int   n  = 0;
    bit   started = 0;
    bit   gap = 0;
    logic ar, lr;
    for (int c = 0; c < ncyc; c++) begin
      aluValid    = (ai < na);
      aluRobIndex = a_idx[ai];
      aluValue    = a_val[ai];
      lsbValid    = (li < nl);
      lsbRobIndex = l_idx[li];
      lsbValue    = l_val[li];
      ar = aluReady;
      lr = lsbReady;
      rdy_log[c] = lr;
      step();
      if (aluValid && ar) ai++;
      if (lsbValid && lr) li++;
      if (cdbValid) begin
        if (n < nexp) chk_bcast($sformatf("%s_b%0d", tag, n), e_idx[n], e_val[n], e_src[n]);
        n++;
        started = 1;
      end else if (started && n < nexp) begin
        gap = 1;
      end
    end
    aluValid = 1'b0;
    lsbValid = 1'b0;
    chk({tag, "_count"}, n, nexp);
    chk({tag, "_gap"}, {31'd0, gap}, 32'd0);
  endtask

  initial begin
    resetIn = 1'b1; clear = 1'b0;
    aluValid = 1'b0; aluRobIndex = '0; aluValue = '0;
    lsbValid = 1'b0; lsbRobIndex = '0; lsbValue = '0;
    step();
    step();
    chk("rst_vld", {31'd0, cdbValid}, 32'd0);
    chk("rst_idx", {28'd0, cdbRobIndex}, 32'd0);
    chk("rst_val", cdbValue, 32'd0);
    chk("rst_src", {31'd0, cdbSource}, 32'd0);
    chk("rst_alurdy", {31'd0, aluReady}, 32'd0);
    chk("rst_lsbrdy", {31'd0, lsbReady}, 32'd0);
    resetIn = 1'b0;
    #1;
    chk("rel_alurdy", {31'd0, aluReady}, 32'd1);
    chk("rel_lsbrdy", {31'd0, lsbReady}, 32'd1);

    // Single ALU result: broadcast in the cycle after the next edge only.
    aluValid = 1'b1; aluRobIndex = 4'd3; aluValue = 32'h0000_00AA;
    step();
    aluValid = 1'b0;
    chk("single_early", {31'd0, cdbValid}, 32'd0);
    step();
    chk_bcast("single", 4'd3, 32'h0000_00AA, 1'b0);
    step();
    chk("single_after", {31'd0, cdbValid}, 32'd0);

    // First conflict after reset goes to the ALU.
    aluValid = 1'b1; aluRobIndex = 4'd1; aluValue = 32'h11;
    lsbValid = 1'b1; lsbRobIndex = 4'd2; lsbValue = 32'h22;
    step();
    aluValid = 1'b0; lsbValid = 1'b0;
    step();
    chk_bcast("conf_a", 4'd1, 32'h11, 1'b0);
    step();
    chk_bcast("conf_l", 4'd2, 32'h22, 1'b1);
    step();
    chk("conf_after", {31'd0, cdbValid}, 32'd0);

    // Four results per source; last grant was ALU, so LSB leads the alternation.
    for (int i = 0; i < 4; i++) begin
      a_idx[i] = 4'(4 + i); a_val[i] = 32'hA0 + i;
      l_idx[i] = 4'(8 + i); l_val[i] = 32'hB0 + i;
    end
    a_idx[4] = '0; a_val[4] = '0; l_idx[4] = '0; l_val[4] = '0;
    e_idx[0] = 4'd8;  e_val[0] = 32'hB0; e_src[0] = 1'b1;
    e_idx[1] = 4'd4;  e_val[1] = 32'hA0; e_src[1] = 1'b0;
    e_idx[2] = 4'd9;  e_val[2] = 32'hB1; e_src[2] = 1'b1;
    e_idx[3] = 4'd5;  e_val[3] = 32'hA1; e_src[3] = 1'b0;
    e_idx[4] = 4'd10; e_val[4] = 32'hB2; e_src[4] = 1'b1;
    e_idx[5] = 4'd6;  e_val[5] = 32'hA2; e_src[5] = 1'b0;
    e_idx[6] = 4'd11; e_val[6] = 32'hB3; e_src[6] = 1'b1;
    e_idx[7] = 4'd7;  e_val[7] = 32'hA3; e_src[7] = 1'b0;
    run_streams(4, 4, 8, 12, "alt");

    // ALU floods six results, LSB sends three with duplicate indices; LSB queue fills.
    for (int i = 0; i < 6; i++) begin
      a_idx[i] = 4'(i); a_val[i] = 32'h100 + i;
    end
    a_idx[6] = '0; a_val[6] = '0;
    for (int i = 0; i < 3; i++) begin
      l_idx[i] = 4'(i + 1); l_val[i] = 32'h200 + i;
    end
    l_idx[3] = '0; l_val[3] = '0;
    e_idx[0] = 4'd0; e_val[0] = 32'h100; e_src[0] = 1'b0;
    e_idx[1] = 4'd1; e_val[1] = 32'h200; e_src[1] = 1'b1;
    e_idx[2] = 4'd1; e_val[2] = 32'h101; e_src[2] = 1'b0;
    e_idx[3] = 4'd2; e_val[3] = 32'h201; e_src[3] = 1'b1;
    e_idx[4] = 4'd2; e_val[4] = 32'h102; e_src[4] = 1'b0;
    e_idx[5] = 4'd3; e_val[5] = 32'h202; e_src[5] = 1'b1;
    e_idx[6] = 4'd3; e_val[6] = 32'h103; e_src[6] = 1'b0;
    e_idx[7] = 4'd4; e_val[7] = 32'h104; e_src[7] = 1'b0;
    e_idx[8] = 4'd5; e_val[8] = 32'h105; e_src[8] = 1'b0;
    run_streams(6, 3, 9, 13, "stall");
    chk("stall_rdy2", {31'd0, rdy_log[2]}, 32'd0);
    chk("stall_rdy3", {31'd0, rdy_log[3]}, 32'd1);
    chk("stall_rdy4", {31'd0, rdy_log[4]}, 32'd0);

    // Clear with entries queued and requests held: nothing accepted, nothing stale later.
    aluValid = 1'b1; aluRobIndex = 4'd12; aluValue = 32'hC0;
    lsbValid = 1'b1; lsbRobIndex = 4'd13; lsbValue = 32'hD0;
    step();
    aluRobIndex = 4'd14; aluValue = 32'hC1;
    lsbRobIndex = 4'd15; lsbValue = 32'hD1;
    step();
    chk_bcast("clr_pre", 4'd12, 32'hC0, 1'b0);
    clear = 1'b1;
    aluRobIndex = 4'd9; aluValue = 32'h99;
    lsbRobIndex = 4'd9; lsbValue = 32'h98;
    #1;
    chk("clr_alurdy", {31'd0, aluReady}, 32'd0);
    chk("clr_lsbrdy", {31'd0, lsbReady}, 32'd0);
    step();
    chk("clr_vld", {31'd0, cdbValid}, 32'd0);
    clear = 1'b0; aluValid = 1'b0; lsbValid = 1'b0;
    #1;
    chk("clr_rel_alurdy", {31'd0, aluReady}, 32'd1);
    chk("clr_rel_lsbrdy", {31'd0, lsbReady}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("clr_quiet%0d", i), {31'd0, cdbValid}, 32'd0);
    end
    // Last grant was ALU before the clear and must still be ALU.
    aluValid = 1'b1; aluRobIndex = 4'd1; aluValue = 32'h1;
    lsbValid = 1'b1; lsbRobIndex = 4'd2; lsbValue = 32'h2;
    step();
    aluValid = 1'b0; lsbValid = 1'b0;
    step();
    chk_bcast("clr_rr_l", 4'd2, 32'h2, 1'b1);
    step();
    chk_bcast("clr_rr_a", 4'd1, 32'h1, 1'b0);

    // Asynchronous reset between edges with data queued.
    aluValid = 1'b1; aluRobIndex = 4'd5; aluValue = 32'h55;
    lsbValid = 1'b1; lsbRobIndex = 4'd6; lsbValue = 32'h66;
    step();
    aluRobIndex = 4'd7; aluValue = 32'h77;
    lsbValid = 1'b0;
    step();
    aluValid = 1'b0;
    chk_bcast("ar_pre", 4'd5, 32'h55, 1'b0);
    #2;
    resetIn = 1'b1;
    #1;
    chk("ar_vld", {31'd0, cdbValid}, 32'd0);
    chk("ar_idx", {28'd0, cdbRobIndex}, 32'd0);
    chk("ar_val", cdbValue, 32'd0);
    chk("ar_src", {31'd0, cdbSource}, 32'd0);
    chk("ar_alurdy", {31'd0, aluReady}, 32'd0);
    chk("ar_lsbrdy", {31'd0, lsbReady}, 32'd0);
    #1;
    resetIn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("ar_quiet%0d", i), {31'd0, cdbValid}, 32'd0);
    end
    aluValid = 1'b1; aluRobIndex = 4'd3; aluValue = 32'h33;
    lsbValid = 1'b1; lsbRobIndex = 4'd4; lsbValue = 32'h44;
    step();
    aluValid = 1'b0; lsbValid = 1'b0;
    step();
    chk_bcast("ar_rr_a", 4'd3, 32'h33, 1'b0);
    step();
    chk_bcast("ar_rr_l", 4'd4, 32'h44, 1'b1);
    step();
    chk("ar_end", {31'd0, cdbValid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
